// File: rtl/frame_streamer_if.sv
// Pixel stream bundle between frame_streamer and CHIP.
// Master drives pixel/valid/markers; slave returns ready.
interface frame_streamer_if;
  logic [7:0] o_pixel;
  logic       o_valid;
  logic       o_frame_start;
  logic       o_last;
  logic       i_ready;

  modport master (
    output o_pixel,
    output o_valid,
    output o_frame_start,
    output o_last,
    input  i_ready
  );

  modport slave (
    input  o_pixel,
    input  o_valid,
    input  o_frame_start,
    input  o_last,
    output i_ready
  );
endinterface

// File: rtl/frame_streamer.sv
// Streams one raster-order frame from memory into CHIP per i_go.
// Optional row gap: define STREAMER_LINE_GAP_EN.
module frame_streamer #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int ADDR_W    = 19,
  parameter int BASE_ADDR = 0,
  parameter int LINE_GAP  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_go,
  frame_streamer_if.master  strm,
  output logic              o_busy,
  output logic              o_done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_q
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int GW = (LINE_GAP > 0) ? $clog2(LINE_GAP + 1) : 1;

  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  typedef struct packed {
    logic       fs;
    logic       last;
    logic [7:0] pix;
  } ent_t;

  logic [1:0]        state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic [GW-1:0]     gcnt;

  logic rd_q;
  logic rd_fs;
  logic rd_last;

  ent_t hd;
  ent_t tl;
  logic hd_v;
  logic tl_v;
  logic done_q;

  logic       pop;
  logic [1:0] load;
  logic       first_rd;
  logic       last_rd;
  ent_t       in_e;

  assign pop      = hd_v & strm.i_ready;
  // A slot freed by this cycle's pop may be refilled, giving 1 pixel/cycle.
  assign load     = {1'b0, hd_v} + {1'b0, tl_v} + {1'b0, rd_q} - {1'b0, pop};
  assign mem_ren  = (state == S_RUN) && (load < 2'd2);
  assign mem_addr = addr;
  assign first_rd = (x == '0) && (y == '0);
  assign last_rd  = (x == X_MAX) && (y == Y_MAX);
  assign in_e     = {rd_fs, rd_last, mem_q};

  assign strm.o_valid       = hd_v;
  assign strm.o_pixel       = hd.pix;
  assign strm.o_frame_start = hd_v & hd.fs;
  assign strm.o_last        = hd_v & hd.last;
  assign o_busy             = (state != S_IDLE);
  assign o_done             = done_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      x     <= '0;
      y     <= '0;
      addr  <= '0;
      gcnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_go) begin
            state <= S_RUN;
            x     <= '0;
            y     <= '0;
            addr  <= ADDR_W'(BASE_ADDR);
          end
        end
        S_RUN: begin
          if (mem_ren) begin
            addr <= addr + ADDR_W'(1);
            if (x == X_MAX) begin
              x <= '0;
              y <= y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
            if (last_rd) begin
              state <= S_DRAIN;
`ifdef STREAMER_LINE_GAP_EN
            end else if (x == X_MAX && LINE_GAP != 0) begin
              state <= S_GAP;
              gcnt  <= GW'(LINE_GAP);
`endif
            end
          end
        end
        S_GAP: begin
          gcnt <= gcnt - GW'(1);
          if (gcnt <= GW'(1)) state <= S_RUN;
        end
        S_DRAIN: begin
          if (pop && hd.last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_q    <= 1'b0;
      rd_fs   <= 1'b0;
      rd_last <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_q    <= mem_ren;
      rd_fs   <= first_rd;
      rd_last <= last_rd;
      done_q  <= pop && hd.last;
    end
  end

  // Head register is the output; tail only fills while the head is stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hd   <= '0;
      tl   <= '0;
      hd_v <= 1'b0;
      tl_v <= 1'b0;
    end else if (pop) begin
      if (tl_v) begin
        hd   <= tl;
        tl   <= in_e;
        tl_v <= rd_q;
      end else begin
        hd   <= in_e;
        hd_v <= rd_q;
      end
    end else if (rd_q) begin
      if (!hd_v) begin
        hd   <= in_e;
        hd_v <= 1'b1;
      end else begin
        tl   <= in_e;
        tl_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer: 4x2 frame at base 100.
// Covers latency, backpressure, ignored i_go, mid-frame reset.
module tb_frame_streamer;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int AW   = 8;
  localparam int BASE = 100;
  localparam int GAP  = 3;
  localparam int N    = W * H;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_go  = 1'b0;
  logic          o_busy;
  logic          o_done;
  logic          mem_ren;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_q = '0;

  frame_streamer_if strm();

  frame_streamer #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW),
    .BASE_ADDR(BASE), .LINE_GAP(GAP)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_go(i_go),
    .strm(strm),
    .o_busy(o_busy), .o_done(o_done),
    .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_q(mem_q)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk)
    if (mem_ren) mem_q <= mem_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int rmode = 0;
  initial begin
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    int k = 0;
    strm.i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      if (rmode == 0) strm.i_ready = 1'b1;
      else begin
        strm.i_ready = pat[k];
        k = (k + 1) % 6;
      end
    end
  end

  logic [9:0] exp_q [$];
  int xfer_idx, done_cnt, last_xfer_cyc, first_xfer_cyc;
  int first_valid_cyc, first_ren_cyc, go_cyc;
  int first_addr, last_addr, idle_since, gap_seen;
  int ren_idle_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [9:0] prev_e;

  initial begin
    logic [9:0] cur, e;
    forever begin
      @(negedge i_clk);
      if (i_rst) stall_prev = 1'b0;
      else begin
        cur = {strm.o_frame_start, strm.o_last, strm.o_pixel};
        if (mem_ren && !o_busy) ren_idle_cnt++;
        if (mem_ren) begin
          if (first_ren_cyc < 0) begin
            first_ren_cyc = cyc;
            first_addr = mem_addr;
          end
          last_addr = mem_addr;
        end
        if (strm.o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stall_prev) begin
          check("stall_valid", strm.o_valid, 1);
          check("stall_hold", cur, prev_e);
        end
        if (o_done) begin
          done_cnt++;
          check("done_lat", cyc, last_xfer_cyc + 1);
          check("done_idle", o_busy, 0);
        end
        if (strm.o_valid && strm.i_ready) begin
          check("sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pixel", cur, e);
          end
          if (xfer_idx == 4) gap_seen = idle_since;
          if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
          xfer_idx++;
          last_xfer_cyc = cyc;
          idle_since = 0;
        end else if (!strm.o_valid) idle_since++;
        stall_prev = strm.o_valid && !strm.i_ready;
        prev_e = cur;
      end
    end
  end

  task automatic clear_mon();
    xfer_idx = 0; done_cnt = 0;
    last_xfer_cyc = -10; first_xfer_cyc = -1;
    first_valid_cyc = -1; first_ren_cyc = -1;
    first_addr = -1; last_addr = -1;
    idle_since = 0; gap_seen = -1;
  endtask

  task automatic start_frame();
    clear_mon();
    for (int i = 0; i < N; i++)
      exp_q.push_back({i == 0, i == N - 1, 8'(BASE + i)});
    @(posedge i_clk); #1;
    i_go = 1'b1;
    go_cyc = cyc;
    @(posedge i_clk); #1;
    i_go = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 300) begin
      @(posedge i_clk);
      t++;
    end
    check("done_seen", done_cnt > 0, 1);
    repeat (4) @(posedge i_clk);
    #1;
    check("sb_empty", exp_q.size(), 0);
    check("xfer_count", xfer_idx, N);
    check("done_once", done_cnt, 1);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {strm.o_valid, strm.o_pixel, strm.o_frame_start,
                strm.o_last, o_busy, o_done, mem_ren, mem_addr}, 0);
  endtask

  initial begin
    clear_mon();
    repeat (3) @(posedge i_clk);
    #1;
    check_zero("reset_outs");
    i_rst = 1'b0;

    // back-to-back frame, ready held high
    rmode = 0;
    start_frame();
    wait_done();
    check("ren_lat", first_ren_cyc, go_cyc + 1);
    check("valid_lat", first_valid_cyc, go_cyc + 3);
    check("first_addr", first_addr, BASE);
    check("last_addr", last_addr, BASE + N - 1);
`ifdef STREAMER_LINE_GAP_EN
    check("row_gap", gap_seen >= GAP, 1);
`else
    check("row_gap", gap_seen, 0);
    check("throughput", last_xfer_cyc - first_xfer_cyc, N - 1);
`endif

    // backpressure pattern
    rmode = 1;
    start_frame();
    wait_done();

    // i_go while busy is ignored
    rmode = 0;
    start_frame();
    repeat (2) @(posedge i_clk);
    #1;
    check("busy_at_go2", o_busy, 1);
    i_go = 1'b1;
    @(posedge i_clk); #1;
    i_go = 1'b0;
    wait_done();
    repeat (10) @(posedge i_clk);
    #1;
    check("no_requeue", done_cnt, 1);
    check("idle_after", o_busy, 0);

    // reset mid-frame
    start_frame();
    begin
      int t = 0;
      while (xfer_idx < 3 && t < 100) begin
        @(posedge i_clk);
        t++;
      end
      check("three_xfers", xfer_idx >= 3, 1);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check_zero("midrst_outs");
    i_rst = 1'b0;
    exp_q.delete();
    done_cnt = 0;
    repeat (5) @(posedge i_clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", o_busy, 0);
    start_frame();
    wait_done();
    check("restart_addr", first_addr, BASE);

    check("ren_outside", ren_idle_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
